// File: rtl/first_counter_pkg.sv
// Shared constants for the first_* counter family (up-counter and down-counter).
package first_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [DEFAULT_WIDTH-1:0] COUNT_MAX = {DEFAULT_WIDTH{1'b1}};

endpackage : first_counter_pkg

// File: rtl/counter_sticky_flag.sv
// Sticky 1-bit flag with synchronous active-low reset; set beats clear.
module counter_sticky_flag (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic flag_out
);

  logic flag_d;
  logic flag_q;

  // next-state: set has priority over clear
  always_comb begin
    flag_d = flag_q;
    if (set) begin
      flag_d = 1'b1;
    end else if (clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // flag register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_out = flag_q;

endmodule : counter_sticky_flag

// File: rtl/first_down_counter.sv
// Loadable down-counter with one-shot / auto-reload modes, terminal-count pulse
// and sticky underflow flag.
module first_down_counter
  import first_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc_pulse,
  output logic             underflow_out,
  output logic             running_out
);

  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_d;
  logic [WIDTH-1:0] reload_q;
  logic [0:0]       state_d;
  logic [0:0]       state_q;
  logic             tc_d;
  logic             tc_q;
  logic             event_s;

  // next-state: load beats decrement; reaching zero replaces the wrap with an event
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    state_d  = state_q;
    event_s  = 1'b0;
    if (load) begin
      cnt_d    = load_value;
      reload_d = load_value;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enable) begin
            if (cnt_q == CNT_ZERO) begin
              event_s = 1'b1;
              if (auto_reload) begin
                cnt_d = reload_q;
              end else begin
                state_d = ST_HALT;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_HALT: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    tc_d = event_s;
  end

  // counter, reload, state and terminal-count registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= CNT_ONES;
      reload_q <= CNT_ONES;
      state_q  <= ST_RUN;
      tc_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  counter_sticky_flag u_underflow_flag (
    .clk      (clk),
    .reset_n  (reset_n),
    .set      (event_s),
    .clr      (clear_flag),
    .flag_out (underflow_out)
  );

  assign counter_out = cnt_q;
  assign tc_pulse    = tc_q;
  assign running_out = (state_q == ST_RUN);

endmodule : first_down_counter

// File: tb/tb_first_down_counter.sv
// Directed self-checking bench for first_down_counter (WIDTH = 4).
module tb_first_down_counter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic       clear_flag;
  logic [3:0] counter_out;
  logic       tc_pulse;
  logic       underflow_out;
  logic       running_out;

  int n_checks = 0;
  int n_fail   = 0;

  first_down_counter #(.WIDTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .load          (load),
    .load_value    (load_value),
    .auto_reload   (auto_reload),
    .clear_flag    (clear_flag),
    .counter_out   (counter_out),
    .tc_pulse      (tc_pulse),
    .underflow_out (underflow_out),
    .running_out   (running_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; load = 1'b1; load_value = 4'd5;
    auto_reload = 1'b0; clear_flag = 1'b0;
    step(); step();
    n_checks++; if (counter_out !== 4'hF) begin n_fail++; $display("FAIL reset_cnt got %h exp %h", counter_out, 4'hF); end
    n_checks++; if (underflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b exp 0", underflow_out); end
    n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b exp 0", tc_pulse); end
    n_checks++; if (running_out !== 1'b1) begin n_fail++; $display("FAIL reset_run got %b exp 1", running_out); end
    reset_n = 1'b1; load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_cnt [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      n_checks++; if (counter_out !== exp_cnt[i]) begin n_fail++; $display("FAIL oneshot_cnt[%0d] got %0d exp %0d", i, counter_out, exp_cnt[i]); end
      n_checks++; if (tc_pulse !== exp_tc[i]) begin n_fail++; $display("FAIL oneshot_tc[%0d] got %b exp %b", i, tc_pulse, exp_tc[i]); end
    end
    n_checks++; if (underflow_out !== 1'b1) begin n_fail++; $display("FAIL oneshot_uf got %b exp 1", underflow_out); end
    n_checks++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL oneshot_run got %b exp 0", running_out); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (counter_out !== 4'd0) begin n_fail++; $display("FAIL halt_cnt[%0d] got %0d exp 0", i, counter_out); end
      n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL halt_tc[%0d] got %b exp 0", i, tc_pulse); end
    end
    n_checks++; if (running_out !== 1'b0) begin n_fail++; $display("FAIL halt_run got %b exp 0", running_out); end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_cnt [9] = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
    logic       exp_tc  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    load = 1'b1; load_value = 4'd2; auto_reload = 1'b1; enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0;
      n_checks++; if (counter_out !== exp_cnt[i]) begin n_fail++; $display("FAIL auto_cnt[%0d] got %0d exp %0d", i, counter_out, exp_cnt[i]); end
      n_checks++; if (tc_pulse !== exp_tc[i]) begin n_fail++; $display("FAIL auto_tc[%0d] got %b exp %b", i, tc_pulse, exp_tc[i]); end
      n_checks++; if (running_out !== 1'b1) begin n_fail++; $display("FAIL auto_run[%0d] got %b exp 1", i, running_out); end
    end
  endtask

  task automatic test_priorities();
    // counter is 0 in RUN: load must beat the pending underflow
    load = 1'b1; load_value = 4'd7; enable = 1'b1;
    step();
    n_checks++; if (counter_out !== 4'd7) begin n_fail++; $display("FAIL prio_load_cnt got %0d exp 7", counter_out); end
    n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL prio_load_tc got %b exp 0", tc_pulse); end
    load = 1'b0; enable = 1'b0; clear_flag = 1'b1;
    step();
    n_checks++; if (underflow_out !== 1'b0) begin n_fail++; $display("FAIL prio_preclear_uf got %b exp 0", underflow_out); end
    clear_flag = 1'b0; load = 1'b1; load_value = 4'd1; auto_reload = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (counter_out !== 4'd0) begin n_fail++; $display("FAIL prio_cnt0 got %0d exp 0", counter_out); end
    clear_flag = 1'b1;
    step();
    n_checks++; if (underflow_out !== 1'b1) begin n_fail++; $display("FAIL prio_set_wins got %b exp 1", underflow_out); end
    n_checks++; if (tc_pulse !== 1'b1) begin n_fail++; $display("FAIL prio_event_tc got %b exp 1", tc_pulse); end
    enable = 1'b0;
    step();
    n_checks++; if (underflow_out !== 1'b0) begin n_fail++; $display("FAIL prio_clear got %b exp 0", underflow_out); end
    clear_flag = 1'b0;
  endtask

  task automatic test_enable_gaps_reset();
    logic [3:0] exp_cnt [5] = '{4'd5, 4'd4, 4'd4, 4'd3, 4'd3};
    logic       en_seq  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    load = 1'b1; load_value = 4'd5; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = en_seq[i];
      step();
      load = 1'b0;
      n_checks++; if (counter_out !== exp_cnt[i]) begin n_fail++; $display("FAIL gap_cnt[%0d] got %0d exp %0d", i, counter_out, exp_cnt[i]); end
    end
    n_checks++; if (running_out !== 1'b1) begin n_fail++; $display("FAIL gap_run got %b exp 1", running_out); end
    reset_n = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (counter_out !== 4'hF) begin n_fail++; $display("FAIL midreset_cnt got %h exp %h", counter_out, 4'hF); end
    n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL midreset_tc got %b exp 0", tc_pulse); end
    n_checks++; if (underflow_out !== 1'b0) begin n_fail++; $display("FAIL midreset_uf got %b exp 0", underflow_out); end
    reset_n = 1'b1; enable = 1'b0;
  endtask

  task automatic test_reload_zero();
    load = 1'b1; load_value = 4'd0; auto_reload = 1'b1; enable = 1'b1;
    step();
    load = 1'b0;
    n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL zero_first_tc got %b exp 0", tc_pulse); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (counter_out !== 4'd0) begin n_fail++; $display("FAIL zero_cnt[%0d] got %0d exp 0", i, counter_out); end
      n_checks++; if (tc_pulse !== 1'b1) begin n_fail++; $display("FAIL zero_tc[%0d] got %b exp 1", i, tc_pulse); end
    end
    n_checks++; if (underflow_out !== 1'b1) begin n_fail++; $display("FAIL zero_uf got %b exp 1", underflow_out); end
    enable = 1'b0;
    step();
    n_checks++; if (tc_pulse !== 1'b0) begin n_fail++; $display("FAIL zero_stop_tc got %b exp 0", tc_pulse); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_priorities();
    test_enable_gaps_reset();
    test_reload_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_first_down_counter

// File: doc/first_down_counter.md
Name: first_down_counter

Overview:
- Loadable down-counter (timer) with underflow detection. It is the count-down counterpart of the team's 4-bit up-counter with overflow flag.
- Counts from a programmed reload value down to zero and flags the underflow event.
- Two modes: one-shot (halts at zero) or auto-reload (periodic).
- Used as a tick/timeout generator beside the up-counter in the counter test designs.

Parameters:
- WIDTH, 4, counter and reload-value width in bits.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous reset, active-low
- enable  input  1  active-high count enable; one decrement per enabled cycle
- load  input  1  active-high; capture load_value into reload register and counter
- load_value  input  WIDTH  value loaded on load
- auto_reload  input  1  1 = reload on underflow; 0 = one-shot, halt at zero
- clear_flag  input  1  active-high clear of sticky underflow_out
- counter_out  output  WIDTH  current count (registered)
- tc_pulse  output  1  one-cycle pulse, the cycle after an underflow event
- underflow_out  output  1  sticky underflow flag (registered)
- running_out  output  1  1 when FSM is in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low. reset_n sampled low at a posedge clk forces:
  - counter_out = all ones, reload register = all ones
  - tc_pulse = 0, underflow_out = 0
  - state = RUN, running_out = 1
- Reset overrides every other input. Reset mid-count discards the count and any pending flag.
- Priority per cycle: reset_n, then load, then enable/decrement. clear_flag is evaluated independently.
- FSM has two states, RUN and HALT.
  - RUN -> HALT: underflow event with auto_reload = 0.
  - HALT -> RUN: load = 1.
  - No other transitions.
- load = 1: counter_out <= load_value and reload register <= load_value. No decrement that cycle, even if enable = 1. State becomes RUN. Takes effect in the same clock edge (latency 1).
- Decrement: in RUN with enable = 1, load = 0 and counter_out != 0, counter_out <= counter_out - 1.
- Underflow event: in RUN with enable = 1, load = 0 and counter_out == 0. On the event:
  - auto_reload = 1: counter_out <= reload register; state stays RUN.
  - auto_reload = 0: counter_out holds 0; state -> HALT.
  - In both modes: underflow_out <= 1, and tc_pulse = 1 for exactly the next cycle.
- HALT: enable is ignored, counter_out holds, and no further events occur.
- Reload register = 0 with auto_reload = 1: an event fires every enabled cycle and tc_pulse stays high while enable is held.
- enable = 0: counter, state and tc_pulse hold/clear. tc_pulse is 0 on any cycle without a preceding event.
- underflow_out is sticky until clear_flag = 1 or reset. If clear_flag and an underflow event occur in the same cycle, set wins (underflow_out = 1).
- auto_reload is sampled only at the event cycle. Changing it mid-count is legal.
- Arithmetic is unsigned modulo 2^WIDTH. The counter never wraps below 0; the underflow path replaces the wrap.
- running_out = (state == RUN).

Decomposition:
- Shared package first_counter_pkg holds:
  - state encoding constants ST_RUN, ST_HALT
  - default WIDTH
  - COUNT_MAX = all-ones constant, also used by the up-counter
- One sub-module, counter_sticky_flag: 1-bit register with synchronous active-low reset, set and clear inputs, set-over-clear priority. It is instantiated for underflow_out and is reusable as the up-counter's overflow flag.

Test Plan (WIDTH = 4):
- Reset: reset_n = 0 for 2 cycles with enable = 1 and load = 1 -> counter_out = 4'hF, underflow_out = 0, tc_pulse = 0, running_out = 1.
- One-shot: load load_value = 3, auto_reload = 0, enable = 1 -> counter_out 3,2,1,0,0. tc_pulse is high one cycle after the first enabled cycle at 0. underflow_out = 1, running_out = 0, and counter_out stays 0 for 5 more enabled cycles.
- Auto-reload: load 2, auto_reload = 1, enable held for 9 cycles -> counter_out 2,1,0,2,1,0,2,1,0; tc_pulse is a single-cycle pulse after each 0.
- Priorities, three cases:
  - load = 1 with enable = 1 at counter_out = 0 -> counter_out = load_value, no tc_pulse.
  - clear_flag = 1 in the same cycle as an underflow event -> underflow_out = 1.
  - clear_flag alone one cycle later -> underflow_out = 0.
- Enable gaps and reset mid-operation: load 5, toggle enable 1,0,1,0 -> counter_out 5,4,4,3,3. Then reset_n = 0 at counter_out = 3 -> counter_out = 4'hF next cycle, tc_pulse = 0.
- Reload = 0 corner: load 0, auto_reload = 1, enable held for 4 cycles -> counter_out stays 0, tc_pulse = 1 on each cycle after the first, underflow_out = 1.
